// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

  // Default line index width: 128 one-word lines, 512 bytes.
  localparam int DEF_INDEX_BITS = 7;

  // Controller state encoding; the registered state is the only control flop.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } cache_state_e;

  // Tag width for a given index width with fixed 4-byte lines.
  function automatic int tag_bits(input int index_bits);
    return 30 - index_bits;
  endfunction

  // Index slice: word address bits above the byte offset.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits);
    return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Tag slice: everything above index and byte offset.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits);
    return addr >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line array: data/tag per line plus valid/dirty bits, one write and one read port.
// Latency: combinational read, writes take effect at the clock edge.
// Backpressure: none; the controller owns all write enables.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = 30 - DEF_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic [31:0]           rd_data_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic                  wr_data_en_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  wr_tag_en_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic                  wr_valid_en_i,
  input  logic                  wr_valid_i,
  input  logic                  wr_dirty_en_i,
  input  logic                  wr_dirty_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [31:0]         data_q  [LINES];
  logic [TAG_BITS-1:0] tag_q   [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;

  assign rd_data_o  = data_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

  // Payload fields carry no reset; a cleared valid bit makes them don't-care.
  always_ff @(posedge clk) begin
    if (wr_data_en_i) data_q[wr_idx_i] <= wr_data_i;
    if (wr_tag_en_i)  tag_q[wr_idx_i]  <= wr_tag_i;
  end

  // Status bits clear synchronously on reset, otherwise follow the per-field enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_valid_en_i) valid_q[wr_idx_i] <= wr_valid_i;
      if (wr_dirty_en_i) dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

endmodule

// File: rtl/dm_wb_cache_ctrl.sv
// Direct-mapped write-back write-allocate cache controller (one word per line).
// Latency: hits complete in the request cycle; misses stall through WRITEBACK/ALLOCATE.
// Backpressure: cache_res_stall holds the pipeline; mem_req_valid held until mem_res_valid.
module dm_wb_cache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cache_req_addr,
  input  logic [31:0] cache_req_data,
  input  logic        cache_req_wen,
  input  logic        cache_req_valid,
  output logic [31:0] cache_res_data,
  output logic        cache_res_stall,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic        mem_req_wen,
  output logic        mem_req_valid,
  input  logic [31:0] mem_res_data,
  input  logic        mem_res_valid
);

  localparam int TAG_BITS = tag_bits(INDEX_BITS);

  cache_state_e state_q, state_d;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [31:0]           line_data;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  line_valid;
  logic                  line_dirty;
  logic                  hit;

  logic                  wr_data_en, wr_tag_en, wr_valid_en, wr_dirty_en;
  logic                  wr_valid, wr_dirty;
  logic [31:0]           wr_data;

  logic                  unused_addr_bits;

  logic [31:0] idx_full, tag_full;
  assign idx_full = addr_index(cache_req_addr, INDEX_BITS);
  assign tag_full = addr_tag(cache_req_addr, INDEX_BITS);
  assign req_idx  = idx_full[INDEX_BITS-1:0];
  assign req_tag  = tag_full[TAG_BITS-1:0];
  // Byte offset and the upper slice-helper bits carry no information here.
  assign unused_addr_bits = ^{cache_req_addr[1:0], idx_full[31:INDEX_BITS], tag_full[31:TAG_BITS]};

  assign hit = line_valid & (line_tag == req_tag);

  cache_line_store #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .rd_idx_i     (req_idx),
    .rd_data_o    (line_data),
    .rd_tag_o     (line_tag),
    .rd_valid_o   (line_valid),
    .rd_dirty_o   (line_dirty),
    .wr_idx_i     (req_idx),
    .wr_data_en_i (wr_data_en),
    .wr_data_i    (wr_data),
    .wr_tag_en_i  (wr_tag_en),
    .wr_tag_i     (req_tag),
    .wr_valid_en_i(wr_valid_en),
    .wr_valid_i   (wr_valid),
    .wr_dirty_en_i(wr_dirty_en),
    .wr_dirty_i   (wr_dirty)
  );

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, pipeline/memory outputs and array write enables.
  always_comb begin
    state_d         = state_q;
    cache_res_data  = '0;
    cache_res_stall = 1'b0;
    mem_req_addr    = '0;
    mem_req_data    = '0;
    mem_req_wen     = 1'b0;
    mem_req_valid   = 1'b0;
    wr_data_en      = 1'b0;
    wr_data         = cache_req_data;
    wr_tag_en       = 1'b0;
    wr_valid_en     = 1'b0;
    wr_valid        = 1'b0;
    wr_dirty_en     = 1'b0;
    wr_dirty        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cache_req_valid) begin
          if (hit) begin
            cache_res_data = line_data;
            if (cache_req_wen) begin
              wr_data_en  = 1'b1;
              wr_dirty_en = 1'b1;
              wr_dirty    = 1'b1;
            end
          end else begin
            cache_res_stall = 1'b1;
            state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        cache_res_stall = 1'b1;
        mem_req_valid   = 1'b1;
        mem_req_wen     = 1'b1;
        mem_req_addr    = {line_tag, req_idx, 2'b00};
        mem_req_data    = line_data;
        if (mem_res_valid) begin
          wr_dirty_en = 1'b1;
          wr_dirty    = 1'b0;
          state_d     = cache_req_valid ? ST_ALLOCATE : ST_IDLE;
        end
      end
      ST_ALLOCATE: begin
        cache_res_stall = 1'b1;
        mem_req_valid   = 1'b1;
        mem_req_addr    = {req_tag, req_idx, 2'b00};
        if (mem_res_valid) begin
          wr_data_en  = 1'b1;
          wr_data     = mem_res_data;
          wr_tag_en   = 1'b1;
          wr_valid_en = 1'b1;
          wr_valid    = 1'b1;
          wr_dirty_en = 1'b1;
          wr_dirty    = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset silences every output and write so nothing leaks from the abandoned state.
    if (rst) begin
      state_d         = ST_IDLE;
      cache_res_data  = '0;
      cache_res_stall = 1'b0;
      mem_req_addr    = '0;
      mem_req_data    = '0;
      mem_req_wen     = 1'b0;
      mem_req_valid   = 1'b0;
      wr_data_en      = 1'b0;
      wr_tag_en       = 1'b0;
      wr_valid_en     = 1'b0;
      wr_dirty_en     = 1'b0;
    end
  end

endmodule
